freq_meas_ctrl: RTL
===================

FREQ_MEAS_CTRL -- requirements
Module: freq_meas_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): NUM_CH, 4, number of external clock channels; CNT_W, 32, counter result width; SETTLE, 4, mux-settle cycles.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- in_sys_clk, in, 1: the single clock.
- in_reset, in, 1: reset, synchronous, active-high.
- in_start, in, 1: scan request, single-cycle pulse.
- in_continuous, in, 1: restart the scan automatically at scan end.
- in_ch_enable, in, NUM_CH: channel enable mask.
- in_period, in, 32: gate length in sys clocks.
- in_cnt_value, in, CNT_W: measured count from the counter.
- in_res_ready, in, 1: result consumer ready.
- out_cnt_reset, out, 1: reset to the counter.
- out_cnt_period, out, 32: period to the counter.
- out_ch_sel, out, clog2(NUM_CH): external clock mux select.
- out_res_valid, out, 1: result valid.
- out_res_ch, out, clog2(NUM_CH): channel of the result.
- out_res_count, out, CNT_W: result count.
- out_busy, out, 1: scan in progress.
- out_scan_done, out, 1: end-of-scan pulse.
- out_cfg_err, out, 1: rejected-start pulse.

Function
REQ-003 The FSM SHALL have the states IDLE, SELECT, GATE, CAPTURE, REPORT and NEXT; all state changes occur on in_sys_clk rising edges.
REQ-004 In IDLE, in_start=1 with in_ch_enable!=0 and in_period>=2 SHALL do the following, then go to SELECT:
- latch the mask into ch_mask;
- latch in_period into out_cnt_period;
- set out_ch_sel to the lowest enabled index.
REQ-005 In IDLE, in_start=1 with a zero mask or in_period<2 SHALL pulse out_cfg_err for 1 cycle and remain in IDLE.
REQ-006 in_start SHALL be ignored in every state other than IDLE.
REQ-007 out_cnt_reset SHALL be 1 in IDLE, SELECT and NEXT, and 0 in GATE, CAPTURE and REPORT.
REQ-008 SELECT SHALL last exactly SETTLE cycles, then go to GATE.
REQ-009 GATE SHALL last exactly out_cnt_period+2 cycles, counted by a 33-bit gate counter so there is no wrap at period=0xFFFFFFFF, then go to CAPTURE.
REQ-010 CAPTURE SHALL last 1 cycle: register in_cnt_value into out_res_count and out_ch_sel into out_res_ch, then go to REPORT.
REQ-011 In REPORT, out_res_valid SHALL be 1, with out_res_count and out_res_ch held stable until in_res_ready=1 is sampled.
REQ-012 The REPORT handshake completes on the cycle valid&&ready; the next cycle SHALL be NEXT with valid=0.
REQ-013 If in_res_ready is already 1 on REPORT entry, valid SHALL be high for exactly 1 cycle.
REQ-014 NEXT SHALL advance out_ch_sel to the next higher enabled index in ch_mask and go to SELECT.
REQ-015 If no higher enabled index exists, NEXT SHALL pulse out_scan_done for 1 cycle, then:
- if in_continuous=1 that cycle: re-latch the mask and period per REQ-004/005 (on error, pulse out_cfg_err and go to IDLE);
- otherwise go to IDLE.
REQ-016 Channel order SHALL be strictly ascending; the latched mask and period SHALL NOT change during a scan.
REQ-017 out_busy SHALL be 1 in every state except IDLE.
REQ-018 A single-channel mask SHALL produce exactly one result per scan.

Reset
REQ-019 in_reset=1 sampled on an edge SHALL force IDLE from any state, including mid-GATE or mid-REPORT, and discard any pending result.
REQ-020 Reset SHALL set these values:
- out_cnt_reset=1;
- out_res_valid=0, out_busy=0, out_scan_done=0, out_cfg_err=0;
- out_ch_sel=0, out_res_ch=0, out_res_count=0, out_cnt_period=0;
- ch_mask=0, gate counter=0.
REQ-021 in_reset SHALL take priority over in_start in the same cycle.

Verification
REQ-022 Basic scan:
- stimulus: mask=4'b0101, period=10, in_cnt_value=1234, ready=1, start pulse;
- response: results ch0 then ch2, each count=1234, each GATE 12 cycles, SELECT 4 cycles, then one out_scan_done and out_busy=0.
REQ-023 Backpressure:
- stimulus: mask=4'b0010, ready=0 for 20 cycles then 1;
- response: valid held 20 cycles with ch=1 and count stable, one handshake, then IDLE.
REQ-024 Config errors:
- stimulus: start with mask=0, then start with period=1;
- response: out_cfg_err pulses twice, out_busy stays 0, out_cnt_reset stays 1.
REQ-025 Continuous mode:
- stimulus: mask=4'b1000, continuous=1, mask changed to 4'b0001 mid-scan;
- response: first scan reports ch3 only; next scan reports ch0 only; no IDLE cycle between scans.
REQ-026 Reset mid-operation:
- stimulus: in_reset in GATE cycle 5 of period 100, and a separate run with in_reset during REPORT;
- response: next cycle IDLE, out_res_valid=0, out_cnt_reset=1, no out_scan_done.
REQ-027 Ignored start:
- stimulus: start pulse during GATE;
- response: scan sequence unchanged and no extra results.

Source files
------------

// File: rtl/freq_meas_ctrl.sv
// freq_meas_ctrl: sequences a multi-channel frequency measurement scan.
// For each enabled channel it selects the external clock, waits for the mux to
// settle, lets the counter run for one gate, captures the count and offers it
// to the consumer through a valid/ready handshake.
module freq_meas_ctrl #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int SETTLE = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              in_sys_clk,
  input  logic              in_reset,
  input  logic              in_start,
  input  logic              in_continuous,
  input  logic [NUM_CH-1:0] in_ch_enable,
  input  logic [31:0]       in_period,
  input  logic [CNT_W-1:0]  in_cnt_value,
  input  logic              in_res_ready,
  output logic              out_cnt_reset,
  output logic [31:0]       out_cnt_period,
  output logic [CH_W-1:0]   out_ch_sel,
  output logic              out_res_valid,
  output logic [CH_W-1:0]   out_res_ch,
  output logic [CNT_W-1:0]  out_res_count,
  output logic              out_busy,
  output logic              out_scan_done,
  output logic              out_cfg_err
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    GATE    = 3'd2,
    CAPTURE = 3'd3,
    REPORT  = 3'd4,
    NEXT    = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_CH-1:0]  ch_mask_q, ch_mask_d;
  logic [31:0]        period_q, period_d;
  logic [CH_W-1:0]    ch_sel_q, ch_sel_d;
  logic [32:0]        gate_cnt_q, gate_cnt_d;
  logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [CH_W-1:0]    res_ch_q, res_ch_d;
  logic [CNT_W-1:0]   res_count_q, res_count_d;
  logic               cfg_err_q, cfg_err_d;

  logic               start_ok;
  logic [CH_W-1:0]    lowest_req_idx;
  logic               higher_found;
  logic [CH_W-1:0]    higher_idx;
  logic [32:0]        gate_last;

  // A new scan needs at least one channel and a gate of two or more clocks.
  assign start_ok  = (|in_ch_enable) && (in_period >= 32'd2);
  // The gate lasts period+2 cycles; 33 bits keep period=0xFFFFFFFF from wrapping.
  assign gate_last = {1'b0, period_q} + 33'd1;

  // Lowest enabled channel of the requested mask, used when a scan starts.
  always_comb begin
    lowest_req_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (in_ch_enable[i]) begin
        lowest_req_idx = CH_W'(i);
      end
    end
  end

  // Next enabled channel above the current one in the latched mask.
  always_comb begin
    higher_found = 1'b0;
    higher_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask_q[i] && (CH_W'(i) > ch_sel_q)) begin
        higher_found = 1'b1;
        higher_idx   = CH_W'(i);
      end
    end
  end

  // Next-state logic and the datapath registers that follow the scan.
  always_comb begin
    state_d      = state_q;
    ch_mask_d    = ch_mask_q;
    period_d     = period_q;
    ch_sel_d     = ch_sel_q;
    gate_cnt_d   = '0;
    settle_cnt_d = '0;
    res_ch_d     = res_ch_q;
    res_count_d  = res_count_q;
    cfg_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_start) begin
          if (start_ok) begin
            ch_mask_d = in_ch_enable;
            period_d  = in_period;
            ch_sel_d  = lowest_req_idx;
            state_d   = SELECT;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      SELECT: begin
        if (settle_cnt_q == SET_W'(SETTLE - 1)) begin
          state_d = GATE;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end
      GATE: begin
        if (gate_cnt_q == gate_last) begin
          state_d = CAPTURE;
        end else begin
          gate_cnt_d = gate_cnt_q + 33'd1;
        end
      end
      CAPTURE: begin
        res_count_d = in_cnt_value;
        res_ch_d    = ch_sel_q;
        state_d     = REPORT;
      end
      REPORT: begin
        if (in_res_ready) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (higher_found) begin
          ch_sel_d = higher_idx;
          state_d  = SELECT;
        end else if (in_continuous) begin
          if (start_ok) begin
            ch_mask_d = in_ch_enable;
            period_d  = in_period;
            ch_sel_d  = lowest_req_idx;
            state_d   = SELECT;
          end else begin
            cfg_err_d = 1'b1;
            state_d   = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge in_sys_clk) begin
    if (in_reset) begin
      state_q      <= IDLE;
      ch_mask_q    <= '0;
      period_q     <= '0;
      ch_sel_q     <= '0;
      gate_cnt_q   <= '0;
      settle_cnt_q <= '0;
      res_ch_q     <= '0;
      res_count_q  <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_mask_q    <= ch_mask_d;
      period_q     <= period_d;
      ch_sel_q     <= ch_sel_d;
      gate_cnt_q   <= gate_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      res_ch_q     <= res_ch_d;
      res_count_q  <= res_count_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign out_cnt_reset  = (state_q == IDLE) || (state_q == SELECT) || (state_q == NEXT);
  assign out_busy       = (state_q != IDLE);
  assign out_res_valid  = (state_q == REPORT);
  assign out_scan_done  = (state_q == NEXT) && !higher_found;
  assign out_cfg_err    = cfg_err_q;
  assign out_cnt_period = period_q;
  assign out_ch_sel     = ch_sel_q;
  assign out_res_ch     = res_ch_q;
  assign out_res_count  = res_count_q;

endmodule
